// File: rtl/lsu_mem_sequencer.sv
// lsu_mem_sequencer: runs each MEM-stage LOAD/STORE as one transaction on a
// req/gnt/rvalid data-memory bus and stalls the pipeline while it is in flight.
// Handshake: dm_req is registered and stays high from REQ entry until the cycle
// dm_gnt is seen (or the access times out). dm_gnt is only meaningful while
// dm_req is high. dm_rvalid is only honoured in REQ (with gnt) and RESP.
// Byte enables, store lane replication and load extension are derived from
// func3/addr at acceptance and held for the whole transaction.
// fsm_state mirrors the internal state register for observation.

`ifndef LOAD
`define LOAD  5'b00000
`endif
`ifndef STORE
`define STORE 5'b01000
`endif

module lsu_mem_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [4:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign_err,
    output logic        timeout_err,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_inc;
    logic               timeout_hit;

    // decode of the instruction currently in the MEM stage
    logic               mem_op;
    logic               is_store;
    logic               sz_byte, sz_half, sz_word;
    logic               misaligned;
    logic [3:0]         be_calc;
    logic [31:0]        wdata_calc;

    // transaction context latched at acceptance
    logic               byte_q, half_q, unsigned_q;
    logic [1:0]         lane_q;

    // per-cycle control from the FSM
    logic               accept;
    logic               capture;
    logic               timed_out;
    logic [31:0]        lane_word;
    logic [31:0]        ext_data;

    assign fsm_state = state_q;

    // Decode the MEM-stage instruction: operation, size, alignment, lanes.
    always_comb begin
        mem_op     = mem_valid & ((opcode == `LOAD) | (opcode == `STORE));
        is_store   = (opcode == `STORE);
        sz_byte    = (func3[1:0] == 2'b00);
        sz_half    = (func3[1:0] == 2'b01);
        sz_word    = func3[1];
        misaligned = (sz_half & addr[0]) | (sz_word & (addr[1:0] != 2'b00));
        be_calc    = 4'b1111;
        wdata_calc = wdata;
        if (sz_byte) begin
            be_calc    = 4'b0001 << addr[1:0];
            wdata_calc = {4{wdata[7:0]}};
        end else if (sz_half) begin
            be_calc    = 4'b0011 << {addr[1], 1'b0};
            wdata_calc = {2{wdata[15:0]}};
        end
    end

    // Next-state logic; completion wins over timeout in the same cycle.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        capture     = 1'b0;
        timed_out   = 1'b0;
        cnt_inc     = cnt_q + 1'b1;
        timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));
        case (state_q)
            S_IDLE: begin
                if (mem_op & ~misaligned & ~rst) begin
                    accept  = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (dm_gnt & dm_we) begin
                    state_d = S_DONE;
                end else if (dm_gnt & dm_rvalid) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    timed_out = 1'b1;
                    state_d   = S_DONE;
                end else if (dm_gnt) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (dm_rvalid) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    timed_out = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pipeline hold: from the accepting cycle through the end of the bus access.
    always_comb begin
        stall = ~rst & (accept | (state_q == S_REQ) | (state_q == S_RESP));
    end

    // Align the selected lane of the read word and extend it to 32 bits.
    always_comb begin
        lane_word = dm_rdata >> {lane_q, 3'b000};
        ext_data  = dm_rdata;
        if (byte_q) begin
            ext_data = unsigned_q ? {24'b0, lane_word[7:0]}
                                  : {{24{lane_word[7]}}, lane_word[7:0]};
        end else if (half_q) begin
            ext_data = unsigned_q ? {16'b0, lane_word[15:0]}
                                  : {{16{lane_word[15]}}, lane_word[15:0]};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Timeout counter: cleared on acceptance, counts every REQ/RESP cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if ((state_q == S_REQ) | (state_q == S_RESP)) begin
            cnt_q <= cnt_inc;
        end
    end

    // Latch the bus command and load-alignment context when an access is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dm_we      <= 1'b0;
            dm_be      <= 4'b0;
            dm_addr    <= 32'b0;
            dm_wdata   <= 32'b0;
            byte_q     <= 1'b0;
            half_q     <= 1'b0;
            unsigned_q <= 1'b0;
            lane_q     <= 2'b0;
        end else if (accept) begin
            dm_we      <= is_store;
            dm_be      <= be_calc;
            dm_addr    <= {addr[31:2], 2'b00};
            dm_wdata   <= wdata_calc;
            byte_q     <= sz_byte;
            half_q     <= sz_half;
            unsigned_q <= func3[2];
            lane_q     <= addr[1:0];
        end
    end

    // Registered request: high exactly while the FSM sits in REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dm_req <= 1'b0;
        else     dm_req <= (state_d == S_REQ);
    end

    // Load result register, updated only by a completed load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          load_data <= 32'b0;
        else if (capture) load_data <= ext_data;
    end

    // One-cycle status pulses, visible in the DONE cycle (or the cycle after a drop).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_valid   <= 1'b0;
            timeout_err  <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            load_valid   <= capture;
            timeout_err  <= timed_out;
            misalign_err <= (state_q == S_IDLE) & mem_op & misaligned;
        end
    end

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Bench for lsu_mem_sequencer: scenario tasks plus randomized back-to-back
// accesses, checked against a transaction-level model of the spec rules.
module tb_lsu_mem_sequencer;

    localparam int TIMEOUT = 15;
    localparam logic [4:0] OPC_LOAD  = 5'b00000;
    localparam logic [4:0] OPC_STORE = 5'b01000;
    localparam logic [4:0] OPC_ALU   = 5'b01100;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign_err;
    logic        timeout_err;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic [1:0]  fsm_state;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_load_data = 32'b0;

    lsu_mem_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .opcode(opcode),
        .func3(func3), .addr(addr), .wdata(wdata), .stall(stall),
        .load_data(load_data), .load_valid(load_valid),
        .misalign_err(misalign_err), .timeout_err(timeout_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        mem_valid = 1'b0;
        opcode    = OPC_ALU;
        func3     = 3'b0;
        addr      = 32'b0;
        wdata     = 32'b0;
        dm_gnt    = 1'b0;
        dm_rvalid = 1'b0;
        dm_rdata  = 32'b0;
    endtask

    // Run one LOAD/STORE from presentation to completion.
    // gw: REQ cycles without gnt before gnt; rw: cycles from gnt to rvalid (0 = same cycle).
    task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int gw, input int rw,
                          input logic [31:0] rd);
        bit          sz_b, sz_h, mis, to;
        int          busy, busy_eff, done_idx, a_lo;
        logic [31:0] e_be, e_wd, shifted, e_ld, old_ld;
        sz_b = (f3[1:0] == 2'b00);
        sz_h = (f3[1:0] == 2'b01);
        a_lo = int'(a[1:0]);
        mis  = (sz_h && a_lo % 2 != 0) || (!sz_b && !sz_h && a_lo != 0);
        if (sz_b) begin
            e_be = 32'(1) << a_lo;
            e_wd = (wd & 32'hFF) * 32'h01010101;
        end else if (sz_h) begin
            e_be = 32'(3) << a_lo;
            e_wd = (wd & 32'hFFFF) * 32'h00010001;
        end else begin
            e_be = 32'hF;
            e_wd = wd;
        end
        shifted = rd >> (8 * a_lo);
        if (sz_b)      e_ld = f3[2] ? (shifted & 32'hFF)   : 32'($signed(shifted[7:0]));
        else if (sz_h) e_ld = f3[2] ? (shifted & 32'hFFFF) : 32'($signed(shifted[15:0]));
        else           e_ld = rd;
        busy     = st ? gw + 1 : gw + 1 + rw;
        to       = busy > TIMEOUT;
        busy_eff = to ? TIMEOUT : busy;
        done_idx = busy_eff + 1;
        old_ld   = exp_load_data;

        mem_valid = 1'b1;
        opcode    = st ? OPC_STORE : OPC_LOAD;
        func3     = f3;
        addr      = a;
        wdata     = wd;
        dm_gnt    = 1'b0;
        dm_rvalid = 1'b0;
        dm_rdata  = $urandom;

        if (mis) begin
            #2;
            n_cmp++;
            if (stall !== 1'b0 || dm_req !== 1'b0) begin
                n_fail++;
                $display("FAIL misalign_nostall a=%h stall=%b req=%b want 0/0", a, stall, dm_req);
            end
            @(posedge clk); #1;
            drive_idle();
            #1;
            n_cmp++;
            if (misalign_err !== 1'b1 || stall !== 1'b0 || dm_req !== 1'b0) begin
                n_fail++;
                $display("FAIL misalign_pulse a=%h err=%b stall=%b req=%b want 1/0/0",
                         a, misalign_err, stall, dm_req);
            end
            @(posedge clk); #1;
            #1;
            n_cmp++;
            if (misalign_err !== 1'b0 || dm_req !== 1'b0) begin
                n_fail++;
                $display("FAIL misalign_end err=%b req=%b want 0/0", misalign_err, dm_req);
            end
            return;
        end

        if (!st && !to) exp_load_data = e_ld;

        for (int c = 0; c <= done_idx; c++) begin
            dm_gnt    = (c == gw + 1) && (c <= busy_eff);
            dm_rvalid = !st && (c == gw + 1 + rw) && (c <= busy_eff);
            dm_rdata  = dm_rvalid ? rd : $urandom;
            #2;
            n_cmp++;
            if (stall !== (c < done_idx)) begin
                n_fail++;
                $display("FAIL stall c=%0d st=%0d gw=%0d rw=%0d got=%b want=%b",
                         c, st, gw, rw, stall, (c < done_idx));
            end
            n_cmp++;
            if (dm_req !== (c >= 1 && c <= gw + 1 && c <= busy_eff)) begin
                n_fail++;
                $display("FAIL dm_req c=%0d st=%0d gw=%0d got=%b want=%b",
                         c, st, gw, dm_req, (c >= 1 && c <= gw + 1 && c <= busy_eff));
            end
            if (c == 1) begin
                n_cmp++;
                if (dm_we !== st || dm_be !== e_be[3:0] || dm_addr !== (a & 32'hFFFFFFFC) ||
                    (st && dm_wdata !== e_wd)) begin
                    n_fail++;
                    $display("FAIL bus_cmd a=%h f3=%0d got we=%b be=%b addr=%h wd=%h want we=%b be=%b addr=%h wd=%h",
                             a, f3, dm_we, dm_be, dm_addr, dm_wdata, st, e_be[3:0],
                             a & 32'hFFFFFFFC, e_wd);
                end
            end
            if (c < done_idx) begin
                n_cmp++;
                if (load_valid !== 1'b0 || timeout_err !== 1'b0 || load_data !== old_ld) begin
                    n_fail++;
                    $display("FAIL busy_status c=%0d lv=%b to=%b ld=%h want 0/0/%h",
                             c, load_valid, timeout_err, load_data, old_ld);
                end
            end else begin
                n_cmp++;
                if (load_valid !== (!st && !to) || timeout_err !== to ||
                    load_data !== exp_load_data) begin
                    n_fail++;
                    $display("FAIL done_status st=%0d f3=%0d a=%h rd=%h got lv=%b to=%b ld=%h want lv=%b to=%b ld=%h",
                             st, f3, a, rd, load_valid, timeout_err, load_data,
                             (!st && !to), to, exp_load_data);
                end
            end
            @(posedge clk); #1;
        end
        drive_idle();
    endtask

    task automatic idle_check(input string tag);
        #2;
        n_cmp++;
        if (stall !== 1'b0 || dm_req !== 1'b0 || load_valid !== 1'b0 ||
            timeout_err !== 1'b0 || misalign_err !== 1'b0 || load_data !== exp_load_data) begin
            n_fail++;
            $display("FAIL idle_%s stall=%b req=%b lv=%b to=%b mis=%b ld=%h want 0/0/0/0/0/%h",
                     tag, stall, dm_req, load_valid, timeout_err, misalign_err,
                     load_data, exp_load_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (stall !== 1'b0 || dm_req !== 1'b0 || dm_we !== 1'b0 || dm_be !== 4'b0 ||
            dm_addr !== 32'b0 || dm_wdata !== 32'b0 || load_data !== 32'b0 ||
            load_valid !== 1'b0 || misalign_err !== 1'b0 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state stall=%b req=%b we=%b be=%b addr=%h wd=%h ld=%h lv=%b mis=%b to=%b want all 0",
                     stall, dm_req, dm_we, dm_be, dm_addr, dm_wdata, load_data,
                     load_valid, misalign_err, timeout_err);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_check("after_reset");
    endtask

    task automatic test_directed();
        run_op(1'b1, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 0, 0, 32'h0);
        run_op(1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 1, 32'h80AB_CDEF);
        n_cmp++;
        if (load_data !== 32'hFFFF_FF80) begin
            n_fail++;
            $display("FAIL lb_sext got=%h want=ffffff80", load_data);
        end
        run_op(1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 1, 32'h80AB_CDEF);
        n_cmp++;
        if (load_data !== 32'h0000_0080) begin
            n_fail++;
            $display("FAIL lbu_zext got=%h want=00000080", load_data);
        end
        run_op(1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 1, 0, 32'h0);
        run_op(1'b0, 3'b101, 32'h0000_0202, 32'h0, 2, 2, 32'hF00D_8001);
        run_op(1'b0, 3'b001, 32'h0000_0200, 32'h0, 0, 0, 32'h1234_9ABC);
        idle_check("after_directed");
    endtask

    task automatic test_misaligned();
        run_op(1'b0, 3'b010, 32'h0000_0101, 32'h0, 0, 0, 32'h0);
        run_op(1'b1, 3'b001, 32'h0000_0203, 32'h5555, 0, 0, 32'h0);
        run_op(1'b0, 3'b101, 32'h0000_0301, 32'h0, 0, 0, 32'h0);
        idle_check("after_misaligned");
    endtask

    task automatic test_timeout();
        run_op(1'b0, 3'b010, 32'h0000_0400, 32'h0, 40, 0, 32'h1111_2222);
        run_op(1'b0, 3'b010, 32'h0000_0404, 32'h0, 2, 40, 32'h3333_4444);
        run_op(1'b1, 3'b010, 32'h0000_0408, 32'hCAFEF00D, TIMEOUT - 1, 0, 32'h0);
        run_op(1'b1, 3'b010, 32'h0000_0408, 32'hCAFEF00D, TIMEOUT, 0, 32'h0);
        run_op(1'b0, 3'b010, 32'h0000_040C, 32'h0, 5, TIMEOUT - 6, 32'h5A5A_A5A5);
        run_op(1'b0, 3'b010, 32'h0000_040C, 32'h0, 5, TIMEOUT - 5, 32'h6B6B_B6B6);
        idle_check("after_timeout");
    endtask

    task automatic test_non_mem_and_stray();
        mem_valid = 1'b1;
        opcode    = OPC_ALU;
        addr      = 32'h0000_0101;
        func3     = 3'b010;
        idle_check("alu_op");
        drive_idle();
        mem_valid = 1'b0;
        opcode    = OPC_LOAD;
        idle_check("no_valid");
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            dm_rvalid = 1'b1;
            dm_gnt    = 1'b1;
            dm_rdata  = $urandom;
            idle_check("stray_rvalid");
        end
        drive_idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 150; i++) begin
            bit          st;
            logic [2:0]  f3;
            logic [31:0] a;
            int          gw, rw;
            st = ($urandom_range(0, 1) == 1);
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                else if (f3[1]) a[1:0] = 2'b00;
            end
            gw = ($urandom_range(0, 14) == 0) ? $urandom_range(12, 17) : $urandom_range(0, 3);
            rw = $urandom_range(0, 3);
            run_op(st, f3, a, $urandom, gw, rw, $urandom);
        end
        idle_check("after_random");
    endtask

    task automatic test_async_reset();
        mem_valid = 1'b1;
        opcode    = OPC_LOAD;
        func3     = 3'b010;
        addr      = 32'h0000_0500;
        @(posedge clk); #1;
        #2;
        n_cmp++;
        if (dm_req !== 1'b1 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre req=%b stall=%b want 1/1", dm_req, stall);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (dm_req !== 1'b0 || stall !== 1'b0 || load_data !== 32'b0) begin
            n_fail++;
            $display("FAIL arst_drop req=%b stall=%b ld=%h want 0/0/0", dm_req, stall, load_data);
        end
        exp_load_data = 32'b0;
        drive_idle();
        @(posedge clk); #1;
        rst = 1'b0;
        idle_check("after_arst");
        run_op(1'b0, 3'b100, 32'h0000_0502, 32'h0, 0, 0, 32'h00C3_0000);
        idle_check("recovered");
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_directed();
        test_misaligned();
        test_timeout();
        test_non_mem_and_stray();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
